lsu_bus_master: RTL and testbench
=================================

LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles in BUS waiting for bus_ack (valid range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=store), req_sel in 3 (defs.vh `MEM_B/`MEM_BU/`MEM_H/`MEM_HU/`MEM_W), req_addr in 32, req_wdata in 32.
REQ-005 SHALL have ports resp_valid out 1, resp_rdata out 32, resp_err out 1.
REQ-006 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_be out 4, bus_wdata out 32, bus_ack in 1, bus_rdata in 32 (word-wide memory, byte lane i = bits 8i+7:8i).

Function
REQ-007 SHALL implement the FSM states IDLE, BUS and RESP.
REQ-008 SHALL assert req_ready only in IDLE and accept a request when req_valid && req_ready, capturing we, sel, addr and wdata.
REQ-009 SHALL treat an accepted request as illegal on: H/HU with addr[0]=1; W with addr[1:0]!=0; sel not one of the five codes; store with sel BU/HU.
REQ-010 SHALL move an illegal request IDLE->RESP with no bus activity, resp_err=1, resp_rdata=`ERR_WORD.
REQ-011 SHALL move a legal request IDLE->BUS and assert bus_req in the next cycle.
REQ-012 SHALL hold bus_req, bus_we, bus_addr, bus_be and bus_wdata constant in BUS until bus_ack is sampled high, then deassert bus_req the following cycle.
REQ-013 SHALL drive bus_addr = {addr[31:2],2'b00}.
REQ-014 SHALL drive bus_be as: B/BU -> 4'b0001 << addr[1:0]; H/HU -> 4'b0011 when addr[1]=0, else 4'b1100; W -> 4'b1111.
REQ-015 SHALL drive bus_wdata as: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
REQ-016 SHALL, on a load ack, extract the addressed lane of bus_rdata; B/H sign-extend and BU/HU zero-extend to 32 bits, W passes through; a store ack returns resp_rdata=0.
REQ-017 SHALL count cycles in BUS; if TIMEOUT cycles elapse without ack, drop bus_req and go to RESP with resp_err=1, resp_rdata=`ERR_WORD.
REQ-018 SHALL pulse resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rdata/resp_err hold until the next response.
REQ-019 SHALL use no response backpressure; resp_valid is a pulse.
REQ-020 SHALL give minimum latency: accept at cycle N, bus_req at N+1, ack at N+1, resp_valid at N+2; one request in flight at most.
REQ-021 SHALL ignore bus_ack outside BUS.
REQ-022 SHALL ignore an ack arriving in the same cycle the timeout expires; the response is the timeout error.
REQ-023 SHALL keep bus_be=0 and bus_we=0 whenever bus_req=0.

Reset
REQ-024 SHALL, while rstn=0, force state=IDLE, req_ready=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, and the counter to 0.
REQ-025 SHALL drop bus_req immediately, with no response, on a reset asserted mid-transaction.
REQ-026 SHALL assert req_ready in the first cycle after rstn deasserts.

Verification
REQ-027 SHALL cover: LB addr=0x103, bus_rdata=0x80FF_FF00, ack next cycle -> bus_addr=0x100, bus_be=4'b1000, resp_rdata=0xFFFF_FF80, resp_err=0.
REQ-028 SHALL cover: SH addr=0x22, wdata=0x1234_ABCD -> bus_be=4'b1100, bus_wdata=0xABCD_ABCD, bus_we=1, resp_rdata=0.
REQ-029 SHALL cover: LW addr=0x6 -> no bus_req, resp_valid at N+1 with resp_err=1, resp_rdata=`ERR_WORD.
REQ-030 SHALL cover: LHU addr=0x2, bus_rdata=0xF00D_0000, ack after 5 wait cycles -> bus_req held 6 cycles with stable outputs, resp_rdata=0x0000_F00D.
REQ-031 SHALL cover: TIMEOUT=4, LW with no ack -> bus_req high exactly 4 cycles, then resp_err=1, resp_rdata=`ERR_WORD.
REQ-032 SHALL cover: rstn low during BUS -> bus_req=0 asynchronously, no resp_valid; after release a new LBU completes normally.

Source files
------------

// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: turns one byte/half/word request at a time into a
// single word-wide bus access and returns an aligned, extended response.
module lsu_bus_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // Access size codes (RISC-V funct3 encoding) and the error response word.
  localparam logic [2:0]  MEM_B    = 3'b000;
  localparam logic [2:0]  MEM_H    = 3'b001;
  localparam logic [2:0]  MEM_W    = 3'b010;
  localparam logic [2:0]  MEM_BU   = 3'b100;
  localparam logic [2:0]  MEM_HU   = 3'b101;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [2:0]  sel_reg;
  logic [1:0]  off_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] resp_rdata_reg, resp_rdata_next;
  logic        resp_err_reg, resp_err_next;
  logic        capture;

  logic        legal_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] load_data;
  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Request decode, evaluated on the raw inputs so it can be captured at accept.
  always_comb begin
    legal_in = 1'b0;
    be_in    = 4'b1111;
    wdata_in = req_wdata;
    case (req_sel)
      MEM_B, MEM_BU: begin
        legal_in = !(req_we && req_sel == MEM_BU);
        be_in    = 4'b0001 << req_addr[1:0];
        wdata_in = {4{req_wdata[7:0]}};
      end
      MEM_H, MEM_HU: begin
        legal_in = !req_addr[0] && !(req_we && req_sel == MEM_HU);
        be_in    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{req_wdata[15:0]}};
      end
      MEM_W: legal_in = (req_addr[1:0] == 2'b00);
      default: legal_in = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = bus_rdata[8*gi +: 8];
  end

  assign byte_sel = lane[off_reg];
  assign half_sel = off_reg[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

  always_comb begin
    case (sel_reg)
      MEM_B:   load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_BU:  load_data = {24'd0, byte_sel};
      MEM_H:   load_data = {{16{half_sel[15]}}, half_sel};
      MEM_HU:  load_data = {16'd0, half_sel};
      MEM_W:   load_data = bus_rdata;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    resp_rdata_next = resp_rdata_reg;
    resp_err_next   = resp_err_reg;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          capture  = 1'b1;
          cnt_next = 8'd0;
          if (legal_in) begin
            state_next = BUS;
          end else begin
            state_next      = RESP;
            resp_err_next   = 1'b1;
            resp_rdata_next = ERR_WORD;
          end
        end
      end
      BUS: begin
        // Expiry wins over a coincident ack.
        if (cnt_reg == CNT_LAST) begin
          state_next      = RESP;
          resp_err_next   = 1'b1;
          resp_rdata_next = ERR_WORD;
        end else if (bus_ack) begin
          state_next      = RESP;
          resp_err_next   = 1'b0;
          resp_rdata_next = we_reg ? 32'd0 : load_data;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      cnt_reg        <= 8'd0;
      we_reg         <= 1'b0;
      sel_reg        <= 3'd0;
      off_reg        <= 2'd0;
      addr_reg       <= 32'd0;
      be_reg         <= 4'd0;
      wdata_reg      <= 32'd0;
      resp_rdata_reg <= 32'd0;
      resp_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      resp_rdata_reg <= resp_rdata_next;
      resp_err_reg   <= resp_err_next;
      if (capture) begin
        we_reg    <= req_we;
        sel_reg   <= req_sel;
        off_reg   <= req_addr[1:0];
        addr_reg  <= {req_addr[31:2], 2'b00};
        be_reg    <= be_in;
        wdata_reg <= wdata_in;
      end
    end
  end

  // Bus strobes derive from state so an asynchronous reset drops them at once.
  assign req_ready  = rstn && (state_reg == IDLE);
  assign bus_req    = (state_reg == BUS);
  assign bus_we     = bus_req && we_reg;
  assign bus_be     = bus_req ? be_reg : 4'b0000;
  assign bus_addr   = addr_reg;
  assign bus_wdata  = wdata_reg;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_lsu_bus_master;

  localparam logic [2:0]  MEM_B    = 3'b000;
  localparam logic [2:0]  MEM_H    = 3'b001;
  localparam logic [2:0]  MEM_W    = 3'b010;
  localparam logic [2:0]  MEM_BU   = 3'b100;
  localparam logic [2:0]  MEM_HU   = 3'b101;
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_valid_4 = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_sel = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        bus_ack = 1'b0, bus_ack_4 = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  logic        req_ready, resp_valid, resp_err, bus_req, bus_we;
  logic [31:0] resp_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        req_ready_4, resp_valid_4, resp_err_4, bus_req_4, bus_we_4;
  logic [31:0] resp_rdata_4, bus_addr_4, bus_wdata_4;
  logic [3:0]  bus_be_4;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  lsu_bus_master dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  lsu_bus_master #(.TIMEOUT(4)) dut_4 (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid_4), .req_ready(req_ready_4), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_4), .resp_rdata(resp_rdata_4), .resp_err(resp_err_4),
    .bus_req(bus_req_4), .bus_we(bus_we_4), .bus_addr(bus_addr_4), .bus_be(bus_be_4),
    .bus_wdata(bus_wdata_4), .bus_ack(bus_ack_4), .bus_rdata(bus_rdata)
  );

  // Reference: size in bytes, alignment, lane mask and extension from first principles.
  function automatic void ref_model(input logic we, input logic [2:0] sel,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [31:0] rdata, output logic legal,
                                    output logic [3:0] be, output logic [31:0] wd,
                                    output logic [31:0] rd);
    int size;
    int off;
    bit sgn;
    bit uns;
    logic [63:0] mask;
    logic [63:0] v;
    size = (sel == MEM_B || sel == MEM_BU) ? 1 :
           (sel == MEM_H || sel == MEM_HU) ? 2 : (sel == MEM_W) ? 4 : 0;
    sgn  = (sel == MEM_B || sel == MEM_H);
    uns  = (sel == MEM_BU || sel == MEM_HU);
    off  = int'(addr % 32'd4);
    legal = (size != 0) ? ((off % size) == 0 && !(we && uns)) : 1'b0;
    if (size == 0) size = 4;
    mask = (64'd1 << (8 * size)) - 64'd1;
    be = 4'(((1 << size) - 1) << off);
    wd = 32'd0;
    for (int k = 0; k < 4 / size; k++)
      wd = wd | 32'(({32'd0, wdata} & mask) << (8 * size * k));
    v = ({32'd0, rdata} >> (8 * off)) & mask;
    if (sgn && v[8 * size - 1]) v = v | ~mask;
    rd = we ? 32'd0 : v[31:0];
  endfunction

  // One transaction on the default-TIMEOUT instance; starts and ends at a negedge in IDLE.
  task automatic run_txn(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                         input string name);
    logic legal;
    logic [3:0] be;
    logic [31:0] wd, rd;
    int req_cycles;
    ref_model(we, sel, addr, wdata, rdata, legal, be, wd, rd);
    req_cycles = 0;
    req_valid = 1'b1; req_we = we; req_sel = sel; req_addr = addr; req_wdata = wdata;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b want 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!legal) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || bus_req !== 1'b0 || resp_err !== 1'b1 || resp_rdata !== ERR_WORD) begin
        errors++;
        $display("FAIL %s illegal: valid=%b bus_req=%b err=%b rdata=%h want 1 0 1 %h",
                 name, resp_valid, bus_req, resp_err, resp_rdata, ERR_WORD);
      end
    end else begin
      for (int k = 0; k <= dly; k++) begin
        @(negedge clk);
        if (bus_req === 1'b1) req_cycles++;
        checks++;
        if (bus_req !== 1'b1 || bus_we !== we || bus_addr !== {addr[31:2], 2'b00} ||
            bus_be !== be || (we && bus_wdata !== wd) || resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s bus cyc%0d: req=%b we=%b addr=%h be=%b wdata=%h want 1 %b %h %b %h",
                   name, k, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                   we, {addr[31:2], 2'b00}, be, wd);
        end
        bus_ack   = (k == dly);
        bus_rdata = (k == dly) ? rdata : $urandom;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || bus_req !== 1'b0 || bus_be !== 4'd0 || bus_we !== 1'b0 ||
          resp_err !== 1'b0 || resp_rdata !== rd || req_cycles != dly + 1) begin
        errors++;
        $display("FAIL %s resp: valid=%b bus_req=%b be=%b err=%b rdata=%h reqcyc=%0d want 1 0 0000 0 %h %0d",
                 name, resp_valid, bus_req, bus_be, resp_err, resp_rdata, req_cycles, rd, dly + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== (legal ? rd : ERR_WORD)) begin
      errors++;
      $display("FAIL %s after: valid=%b ready=%b rdata=%h want 0 1 %h",
               name, resp_valid, req_ready, resp_rdata, legal ? rd : ERR_WORD);
    end
    txn_no++;
    $display("txn %0d %s we=%b sel=%0d addr=%h wdata=%h legal=%b resp=%h err=%b",
             txn_no, name, we, sel, addr, wdata, legal, resp_rdata, resp_err);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || bus_req !== 1'b0 || bus_we !== 1'b0 || bus_be !== 4'd0 ||
        bus_addr !== 32'd0 || bus_wdata !== 32'd0 || resp_valid !== 1'b0 ||
        resp_err !== 1'b0 || resp_rdata !== 32'd0 || bus_req_4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b req=%b we=%b be=%b addr=%h wd=%h v=%b e=%b rd=%h want all 0",
               req_ready, bus_req, bus_we, bus_be, bus_addr, bus_wdata, resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || req_ready_4 !== 1'b1) begin
      errors++; $display("FAIL reset_release ready: got %b %b want 1 1", req_ready, req_ready_4);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_txn(1'b0, MEM_B,  32'h103, 32'h0,         32'h80FF_FF00, 0, "lb_103");
    run_txn(1'b1, MEM_H,  32'h22,  32'h1234_ABCD, 32'h5555_5555, 0, "sh_22");
    run_txn(1'b0, MEM_W,  32'h6,   32'h0,         32'h0,         0, "lw_misaligned");
    run_txn(1'b0, MEM_HU, 32'h2,   32'h0,         32'hF00D_0000, 5, "lhu_wait5");
    run_txn(1'b1, MEM_BU, 32'h10,  32'h77,        32'h0,         0, "sbu_illegal");
    run_txn(1'b0, 3'b011, 32'h0,   32'h0,         32'h0,         0, "bad_sel");
  endtask

  // Drives one LW on the TIMEOUT=4 instance; ack_at is the 1-based bus cycle to ack (0 = never).
  task automatic t4_txn(input int ack_at, input int exp_cycles, input logic exp_err,
                        input string name);
    int hi;
    bit got;
    logic [31:0] exp_rd;
    hi = 0; got = 1'b0;
    exp_rd = exp_err ? ERR_WORD : 32'hCAFE_0123;
    bus_rdata = 32'hCAFE_0123;
    req_valid_4 = 1'b1; req_we = 1'b0; req_sel = MEM_W; req_addr = 32'h40; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid_4 = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (resp_valid_4 === 1'b1) got = 1'b1;
      else if (bus_req_4 === 1'b1) hi++;
      bus_ack_4 = !got && (ack_at != 0) && (hi == ack_at);
    end
    bus_ack_4 = 1'b0;
    checks++;
    if (!got || hi != exp_cycles || resp_err_4 !== exp_err || resp_rdata_4 !== exp_rd) begin
      errors++;
      $display("FAIL %s: seen=%0d reqcyc=%0d err=%b rdata=%h want 1 %0d %b %h",
               name, got, hi, resp_err_4, resp_rdata_4, exp_cycles, exp_err, exp_rd);
    end
    @(negedge clk);
    txn_no++;
    $display("txn %0d %s reqcyc=%0d err=%b rdata=%h", txn_no, name, hi, resp_err_4, resp_rdata_4);
  endtask

  task automatic test_timeout();
    t4_txn(0, 4, 1'b1, "t4_no_ack");
    t4_txn(4, 4, 1'b1, "t4_ack_at_expiry");
    t4_txn(3, 3, 1'b0, "t4_ack_before_expiry");
  endtask

  task automatic test_ack_outside();
    bus_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || bus_req !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL ack_in_idle cyc%0d: valid=%b req=%b ready=%b want 0 0 1",
                 c, resp_valid, bus_req, req_ready);
      end
    end
    bus_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    req_valid = 1'b1; req_we = 1'b0; req_sel = MEM_W; req_addr = 32'h80; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL mid_reset pre: bus_req=%b want 1", bus_req);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b0 || bus_be !== 4'd0 || req_ready !== 1'b0 || bus_addr !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset async: req=%b be=%b ready=%b addr=%h want 0 0000 0 0",
               bus_req, bus_be, req_ready, bus_addr);
    end
    bus_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || bus_req !== 1'b0) begin
        errors++; $display("FAIL mid_reset hold cyc%0d: valid=%b req=%b want 0 0", c, resp_valid, bus_req);
      end
    end
    bus_ack = 1'b0;
    rstn = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL mid_reset release cyc%0d: valid=%b ready=%b want 0 1", c, resp_valid, req_ready);
      end
      @(negedge clk);
    end
    run_txn(1'b0, MEM_BU, 32'h201, 32'h0, 32'h1234_9A78, 1, "lbu_after_reset");
  endtask

  task automatic test_random_back_to_back();
    logic [2:0] sels [8];
    sels = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU, MEM_W, 3'b110, 3'b111};
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), sels[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
              int'($urandom_range(0, 4)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ack_outside();
    test_mid_reset();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
